ctrlu_mc: RTL and testbench
===========================

CTRLU_MC -- requirements
Module: ctrlu_mc

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independently controlled CPU channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of each per-channel run-cycle counter and of the budget.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port hps_cmd, input, N_CH bits, the per-channel HPS command level; bit i belongs to channel i.
REQ-006 The block SHALL have port cpu_halt, input, N_CH bits, the per-channel CPU halt indication.
REQ-007 The block SHALL have port budget, input, CNT_W bits, the run-cycle limit shared by all channels; 0 means unlimited.
REQ-008 The block SHALL have port sel, input, 4 bits, the channel index for the run_cnt readout.
REQ-009 The block SHALL have port state, output, 2*N_CH bits, the per-channel state; bits [2i+1:2i] belong to channel i.
REQ-010 The block SHALL have port alive, output, N_CH bits, the per-channel "CPU running" flag.
REQ-011 The block SHALL have port cause, output, 2*N_CH bits, the per-channel last stop cause: 00 none, 01 halt, 10 hps, 11 timeout.
REQ-012 The block SHALL have port run_cnt, output, CNT_W bits, the run-cycle counter of the channel selected by sel.
REQ-013 The block SHALL have port all_stopped, output, 1 bit, high when every channel is in STOPPED.

Function
REQ-014 Each channel SHALL run an identical, independent 4-state machine with encodings STOPPED=00, STARTING=01, STOPPING=10, STARTED=11.
REQ-015 In STOPPED, if hps_cmd[i]=1, the channel SHALL go to STARTING, clear its run counter to 0 and set its cause to 00; otherwise it SHALL hold.
REQ-016 In STARTING, if hps_cmd[i]=0, the channel SHALL go to STARTED and set alive[i]=1; otherwise it SHALL hold.
REQ-017 In STOPPING, if hps_cmd[i]=0, the channel SHALL go to STOPPED; otherwise it SHALL hold.
REQ-018 In STARTED, exits SHALL be evaluated in fixed priority order: hps_cmd, then cpu_halt, then timeout.
REQ-019 In STARTED with hps_cmd[i]=1, the channel SHALL go to STOPPING with alive[i]=0 and cause=10, regardless of cpu_halt or timeout.
REQ-020 In STARTED with hps_cmd[i]=0 and cpu_halt[i]=1, the channel SHALL go to STOPPED with alive[i]=0 and cause=01.
REQ-021 In STARTED with neither exit taken, budget!=0 and counter >= budget-1, the channel SHALL go to STOPPED with alive[i]=0 and cause=11.
REQ-022 The run counter SHALL increment by 1 on every STARTED cycle that takes no hps or halt exit, including a timeout cycle, and SHALL saturate at all-ones.
REQ-023 As a result of REQ-021 and REQ-022, alive[i] SHALL be high for exactly budget cycles when the run ends by timeout.
REQ-024 The comparison against budget SHALL use the live budget value each cycle, so lowering budget below the current count times the channel out on the next edge.
REQ-025 The run counter and cause SHALL hold their values in all other cases, so both remain readable after a stop.
REQ-026 run_cnt SHALL combinationally reflect the counter of channel sel, and SHALL be 0 when sel >= N_CH.
REQ-027 all_stopped SHALL be the combinational AND of (state==STOPPED) over all channels, derived from registered state only.
REQ-028 hps_cmd and cpu_halt SHALL be treated as synchronous to clk; the block SHALL NOT add synchronisers.

Reset
REQ-029 Asserting rst SHALL immediately force every channel to STOPPED, set alive=0, set cause=00 and set the run counter to 0, independent of clk.
REQ-030 A reset asserted mid-run SHALL abort the run without recording a cause.
REQ-031 After rst deasserts, the first transition SHALL occur on the first rising edge of clk.

Verification
REQ-032 Start/stop handshake: N_CH=4, budget=0, pulse hps_cmd[0] high for 3 cycles then low -> state[1:0] goes 00->01->11 and alive[0]=1; a second hps_cmd[0] pulse gives 11->10->00 with cause[1:0]=10; channels 1-3 stay 00.
REQ-033 Halt: channel 1 in STARTED, cpu_halt[1]=1 for 1 cycle -> next edge state 00, alive[1]=0, cause=01; selecting sel=1 shows run_cnt equal to the number of cycles spent in STARTED.
REQ-034 Timeout: budget=5, start channel 2 -> alive[2] high for exactly 5 cycles, cause=11, and run_cnt=5 with sel=2.
REQ-035 Priority: in STARTED, with hps_cmd and cpu_halt rising on the same cycle and run_cnt=budget-1 -> STOPPING with cause=10.
REQ-036 Reset mid-run: all channels STARTED, assert rst between clock edges -> all outputs return to reset values immediately and all_stopped=1.
REQ-037 Edge cases: with CNT_W=4 and budget=0, run 20 cycles -> run_cnt saturates at 15; sel=7 with N_CH=4 -> run_cnt=0.

Source files
------------

// File: rtl/ctrlu_mc.sv
// ctrlu_mc: per-channel CPU start/stop controller with run-cycle budget and cause tracking
module ctrlu_mc #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    hps_cmd,
  input  logic [N_CH-1:0]    cpu_halt,
  input  logic [CNT_W-1:0]   budget,
  input  logic [3:0]         sel,
  output logic [2*N_CH-1:0]  state,
  output logic [N_CH-1:0]    alive,
  output logic [2*N_CH-1:0]  cause,
  output logic [CNT_W-1:0]   run_cnt,
  output logic               all_stopped
);
  typedef enum logic [1:0] {
    STOPPED  = 2'b00,
    STARTING = 2'b01,
    STOPPING = 2'b10,
    STARTED  = 2'b11
  } st_t;
  logic [CNT_W-1:0] cnt_all [N_CH];
  logic [N_CH-1:0]  stopped;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    st_t              st_q, st_d;
    logic             alive_q, alive_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    // live budget compare: the counter value that makes this the budget-th STARTED cycle
    assign hit = (budget != '0) && (cnt_q >= budget - CNT_W'(1));
    // channel state register; reset aborts any run without recording a cause
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q    <= STOPPED;
        alive_q <= 1'b0;
        cause_q <= 2'b00;
        cnt_q   <= '0;
      end else begin
        st_q    <= st_d;
        alive_q <= alive_d;
        cause_q <= cause_d;
        cnt_q   <= cnt_d;
      end
    end
    // next state: STARTED exits are hps, then halt, then timeout
    always_comb begin
      st_d    = st_q;
      alive_d = alive_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      case (st_q)
        STOPPED: if (hps_cmd[i]) begin
          st_d    = STARTING;
          cnt_d   = '0;
          cause_d = 2'b00;
        end
        STARTING: if (!hps_cmd[i]) begin
          st_d    = STARTED;
          alive_d = 1'b1;
        end
        STOPPING: if (!hps_cmd[i]) st_d = STOPPED;
        STARTED: if (hps_cmd[i]) begin
          st_d    = STOPPING;
          alive_d = 1'b0;
          cause_d = 2'b10;
        end else if (cpu_halt[i]) begin
          st_d    = STOPPED;
          alive_d = 1'b0;
          cause_d = 2'b01;
        end else begin
          cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
          if (hit) begin
            st_d    = STOPPED;
            alive_d = 1'b0;
            cause_d = 2'b11;
          end
        end
        default: st_d = STOPPED;
      endcase
    end
    assign state[2*i +: 2] = st_q;
    assign cause[2*i +: 2] = cause_q;
    assign alive[i]        = alive_q;
    assign cnt_all[i]      = cnt_q;
    assign stopped[i]      = (st_q == STOPPED);
  end
  assign all_stopped = &stopped;
  // counter readout mux; out-of-range selects read as zero
  always_comb begin
    run_cnt = '0;
    for (int k = 0; k < N_CH; k++) run_cnt = (sel == 4'(k)) ? cnt_all[k] : run_cnt;
  end
endmodule

// File: tb/tb_ctrlu_mc.sv
// tb_ctrlu_mc: directed scoreboard bench for ctrlu_mc
module tb_ctrlu_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  hps_cmd = '0, cpu_halt = '0, sel = '0;
  logic [31:0] budget = '0;
  logic [7:0]  state, cause;
  logic [3:0]  alive;
  logic [31:0] run_cnt;
  logic        all_stopped;
  logic [1:0]  hps2 = '0, halt2 = '0;
  logic [3:0]  budget2 = '0, sel2 = '0, run_cnt2;
  logic [3:0]  state2, cause2;
  logic [1:0]  alive2;
  logic        all_stopped2;
  int          errors = 0, checks = 0, n_alive;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  ctrlu_mc #(.N_CH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hps_cmd(hps_cmd), .cpu_halt(cpu_halt), .budget(budget), .sel(sel),
    .state(state), .alive(alive), .cause(cause), .run_cnt(run_cnt), .all_stopped(all_stopped)
  );
  ctrlu_mc #(.N_CH(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .hps_cmd(hps2), .cpu_halt(halt2), .budget(budget2), .sel(sel2),
    .state(state2), .alive(alive2), .cause(cause2), .run_cnt(run_cnt2), .all_stopped(all_stopped2)
  );
  always #5 clk = ~clk;
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_val(string t, logic [31:0] v);
    sb.push_back('{t, v});
  endtask
  task automatic check(logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask
  initial begin
    #2;
    expect_val("rst_state", 0);        check(state);
    expect_val("rst_alive", 0);        check(alive);
    expect_val("rst_cause", 0);        check(cause);
    expect_val("rst_all_stopped", 1); check(all_stopped);
    expect_val("rst_run_cnt", 0);      check(run_cnt);
    rst = 1'b0;
    tick();
    // start/stop handshake on channel 0
    hps_cmd[0] = 1'b1;
    expect_val("hs_starting", 8'h01); tick(); check(state);
    expect_val("hs_starting_hold", 8'h01); tick(2); check(state);
    hps_cmd[0] = 1'b0;
    expect_val("hs_started", 8'h03); tick(); check(state);
    expect_val("hs_alive", 4'h1); check(alive);
    hps_cmd[0] = 1'b1;
    expect_val("hs_stopping", 8'h02); tick(); check(state);
    expect_val("hs_stop_alive", 4'h0); check(alive);
    hps_cmd[0] = 1'b0;
    expect_val("hs_stopped", 8'h00); tick(); check(state);
    expect_val("hs_cause", 8'h02); check(cause);
    // halt on channel 1 after 3 counted STARTED cycles
    hps_cmd[1] = 1'b1; tick(); hps_cmd[1] = 1'b0;
    expect_val("halt_started", 8'h0c); tick(); check(state);
    tick(3);
    cpu_halt[1] = 1'b1;
    expect_val("halt_state", 8'h00); tick(); check(state);
    cpu_halt[1] = 1'b0;
    expect_val("halt_alive", 4'h0); check(alive);
    expect_val("halt_cause", 8'h06); check(cause);
    sel = 4'd1;
    expect_val("halt_run_cnt", 3); #1 check(run_cnt);
    // timeout on channel 2 with budget 5
    budget = 5;
    hps_cmd[2] = 1'b1; tick(); hps_cmd[2] = 1'b0; tick();
    n_alive = 0;
    for (int k = 0; k < 20 && alive[2]; k++) begin
      n_alive++;
      tick();
    end
    expect_val("to_alive_cycles", 5); check(n_alive);
    expect_val("to_cause", 8'h36); check(cause);
    sel = 4'd2;
    expect_val("to_run_cnt", 5); #1 check(run_cnt);
    expect_val("to_state", 8'h00); check(state);
    // priority on channel 3: hps beats halt and timeout
    budget = 3;
    hps_cmd[3] = 1'b1; tick(); hps_cmd[3] = 1'b0; tick(3);
    sel = 4'd3;
    expect_val("pri_cnt_at_limit", 2); #1 check(run_cnt);
    hps_cmd[3] = 1'b1; cpu_halt[3] = 1'b1;
    expect_val("pri_state", 8'h80); tick(); check(state);
    expect_val("pri_cause", 8'hb6); check(cause);
    hps_cmd[3] = 1'b0; cpu_halt[3] = 1'b0;
    expect_val("pri_stopped", 8'h00); tick(); check(state);
    // live budget lowered below the current count
    budget = 0;
    hps_cmd[0] = 1'b1; tick(); hps_cmd[0] = 1'b0; tick(6);
    sel = 4'd0;
    expect_val("live_cnt", 5); #1 check(run_cnt);
    budget = 2;
    expect_val("live_state", 8'h00); tick(); check(state);
    expect_val("live_cause", 8'hb7); check(cause);
    expect_val("live_run_cnt", 6); check(run_cnt);
    budget = 0;
    // asynchronous reset mid-run
    hps_cmd = 4'hf; tick(); hps_cmd = 4'h0;
    expect_val("ar_all_started", 8'hff); tick(); check(state);
    expect_val("ar_not_all_stopped", 0); check(all_stopped);
    #2 rst = 1'b1;
    #1;
    expect_val("ar_state", 0);        check(state);
    expect_val("ar_alive", 0);        check(alive);
    expect_val("ar_cause", 0);        check(cause);
    expect_val("ar_all_stopped", 1); check(all_stopped);
    expect_val("ar_run_cnt", 0);      check(run_cnt);
    #2 rst = 1'b0;
    expect_val("ar_hold", 0); tick(); check(state);
    // saturation with CNT_W=4 and out-of-range select
    hps2[0] = 1'b1; tick(); hps2[0] = 1'b0; tick(21);
    expect_val("sat_run_cnt", 15); check(run_cnt2);
    expect_val("sat_state", 4'h3); check(state2);
    sel = 4'd7;
    hps_cmd[1] = 1'b1; tick(); hps_cmd[1] = 1'b0; tick(3);
    expect_val("sel_oor", 0); check(run_cnt);
    sel = 4'd1;
    expect_val("sel_in_range", 2); #1 check(run_cnt);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
